// File: rtl/dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_pkg
//  Description : Shared types and constants for the multi-hart debug
//                run-control and abstract register access controller.
//  Revision    : 1.0  initial release
// ============================================================================
package dbg_pkg;

    typedef enum logic [1:0] {
        HS_RUNNING     = 2'd0,
        HS_HALT_PEND   = 2'd1,
        HS_HALTED      = 2'd2,
        HS_RESUME_PEND = 2'd3
    } hart_state_e;

    typedef enum logic [1:0] {
        AR_IDLE   = 2'd0,
        AR_ACCESS = 2'd1,
        AR_DONE   = 2'd2
    } ar_state_e;

    // Which resource an accepted abstract access targets
    typedef enum logic [1:0] {
        AK_DCSR = 2'd0,
        AK_DPC  = 2'd1,
        AK_GPR  = 2'd2,
        AK_CSR  = 2'd3
    } ar_kind_e;

    localparam logic [2:0]  CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0]  CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0]  CAUSE_STEP    = 3'd4;

    localparam logic [15:0] DCSR_AD  = 16'h07B0;
    localparam logic [15:0] DPC_AD   = 16'h07B1;
    localparam logic [15:0] GPR_BASE = 16'h1000;
    localparam logic [15:0] GPR_LAST = 16'h101F;

    // xdebugver=4, prv=M, everything else clear
    localparam logic [31:0] DCSR_RESET = 32'h4000_0003;

    // Assemble the architectural dcsr view from the few stored fields
    function automatic logic [31:0] dcsr_pack(input logic       ebreakm,
                                              input logic [2:0] cause,
                                              input logic       step);
        dcsr_pack = DCSR_RESET | {16'h0, ebreakm, 6'h0, cause, 3'h0, step, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hart_dbg_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : hart_dbg_fsm
//  Description : Run-control state, dpc and dcsr of a single hart.
//                Optional macro DBG_SINGLE_STEP_EN enables dcsr.step and the
//                auto-halt after one retired instruction.
//  Revision    : 1.0  initial release
// ============================================================================
module hart_dbg_fsm
    import dbg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        halt_req_i,
    input  logic        resume_req_i,
    input  logic        ebreak_i,
    input  logic [31:0] ebreak_pc_i,
    input  logic [31:0] next_pc_i,
    input  logic        fetch_busy_i,
    input  logic        inst_valid_wb_i,
    input  logic        dpc_we_i,
    input  logic        dcsr_we_i,
    input  logic [31:0] wdata_i,
    output logic        halt_o,
    output logic        resume_o,
    output logic [31:0] resume_pc_o,
    output logic        halted_o,
    output logic        running_o,
    output logic        resumeack_o,
    output logic [31:0] dpc_o,
    output logic [31:0] dcsr_o
);

    hart_state_e state_q, state_d;
    logic [31:0] dpc_q, dpc_d;
    logic [2:0]  cause_q, cause_d;
    logic        ebreakm_q, ebreakm_d;
    logic        step_q, step_d;
    logic        ack_q, ack_d;

`ifndef DBG_SINGLE_STEP_EN
    logic unused_step;
    assign unused_step = inst_valid_wb_i;
`endif

    // Next-state, dpc capture and dcsr field updates
    always_comb begin
        state_d   = state_q;
        dpc_d     = dpc_q;
        cause_d   = cause_q;
        ebreakm_d = ebreakm_q;
        step_d    = step_q;
        ack_d     = ack_q;
        case (state_q)
            HS_RUNNING: begin
                if (ebreak_i && ebreakm_q) begin
                    state_d = HS_HALT_PEND;
                    cause_d = CAUSE_EBREAK;
                    dpc_d   = ebreak_pc_i;
                end else if (halt_req_i) begin
                    state_d = HS_HALT_PEND;
                    cause_d = CAUSE_HALTREQ;
`ifdef DBG_SINGLE_STEP_EN
                end else if (step_q && inst_valid_wb_i) begin
                    state_d = HS_HALT_PEND;
                    cause_d = CAUSE_STEP;
                    dpc_d   = next_pc_i;
`endif
                end
            end
            HS_HALT_PEND: begin
                // Halt only once no fetch is in flight; a haltreq stops at
                // the oldest unretired instruction
                if (!fetch_busy_i) begin
                    state_d = HS_HALTED;
                    if (cause_q == CAUSE_HALTREQ) begin
                        dpc_d = next_pc_i;
                    end
                end
            end
            HS_HALTED: begin
                if (resume_req_i && !halt_req_i) begin
                    state_d = HS_RESUME_PEND;
                    ack_d   = 1'b0;
                end
                if (dpc_we_i) begin
                    dpc_d = wdata_i;
                end
                if (dcsr_we_i) begin
                    ebreakm_d = wdata_i[15];
`ifdef DBG_SINGLE_STEP_EN
                    step_d    = wdata_i[2];
`endif
                end
            end
            HS_RESUME_PEND: begin
                state_d = HS_RUNNING;
                ack_d   = 1'b1;
            end
            default: state_d = HS_RUNNING;
        endcase
    end

    // State and field registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= HS_RUNNING;
            dpc_q     <= RESET_PC;
            cause_q   <= 3'd0;
            ebreakm_q <= 1'b0;
            step_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dpc_q     <= dpc_d;
            cause_q   <= cause_d;
            ebreakm_q <= ebreakm_d;
            step_q    <= step_d;
            ack_q     <= ack_d;
        end
    end

    assign halt_o      = (state_q == HS_HALT_PEND) || (state_q == HS_HALTED);
    assign resume_o    = (state_q == HS_RESUME_PEND);
    assign halted_o    = (state_q == HS_HALTED);
    assign running_o   = (state_q == HS_RUNNING);
    assign resumeack_o = ack_q;
    assign resume_pc_o = dpc_q;
    assign dpc_o       = dpc_q;
    assign dcsr_o      = dcsr_pack(ebreakm_q, cause_q, step_q);

endmodule
`default_nettype wire

// File: rtl/dbg_hart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_hart_ctrl
//  Description : Multi-hart run control plus abstract GPR/CSR/dcsr/dpc access
//                between the debug module and NUM_HARTS cores. Per-hart state
//                lives in hart_dbg_fsm; single-step follows DBG_SINGLE_STEP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module dbg_hart_ctrl
    import dbg_pkg::*;
#(
    parameter  int          NUM_HARTS = 2,
    parameter  int          AR_LAT    = 1,
    parameter  logic [31:0] RESET_PC  = 32'h0000_0000,
    localparam int          HW        = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
)(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [HW-1:0]           hartsel_i,
    input  logic                    haltreq_i,
    input  logic                    resumereq_i,
    input  logic [NUM_HARTS-1:0]    ebreak_i,
    input  logic [NUM_HARTS*32-1:0] ebreak_pc_i,
    input  logic [NUM_HARTS*32-1:0] next_pc_i,
    input  logic [NUM_HARTS-1:0]    fetch_busy_i,
    input  logic [NUM_HARTS-1:0]    inst_valid_wb_i,
    output logic [NUM_HARTS-1:0]    halt_o,
    output logic [NUM_HARTS-1:0]    resume_o,
    output logic [NUM_HARTS*32-1:0] resume_pc_o,
    output logic [NUM_HARTS-1:0]    halted_o,
    output logic [NUM_HARTS-1:0]    running_o,
    output logic [NUM_HARTS-1:0]    resumeack_o,
    output logic                    anyhalted_o,
    output logic                    allhalted_o,
    output logic                    anyrunning_o,
    output logic                    allrunning_o,
    input  logic                    ar_en_i,
    input  logic                    ar_wr_i,
    input  logic [15:0]             ar_ad_i,
    input  logic [31:0]             ar_do_i,
    output logic [31:0]             ar_di_o,
    output logic                    ar_done_o,
    output logic                    ar_err_o,
    output logic                    gpr_en_o,
    output logic                    gpr_wr_o,
    output logic [4:0]              gpr_ad_o,
    output logic [31:0]             gpr_wdata_o,
    input  logic [31:0]             gpr_rdata_i,
    output logic                    csr_en_o,
    output logic                    csr_wr_o,
    output logic [11:0]             csr_ad_o,
    output logic [31:0]             csr_wdata_o,
    input  logic [31:0]             csr_rdata_i,
    output logic [HW-1:0]           gpr_hart_o
);

    logic [NUM_HARTS-1:0] halt_sel, resume_sel, dpc_we, dcsr_we;
    logic [31:0]          dpc_w  [NUM_HARTS];
    logic [31:0]          dcsr_w [NUM_HARTS];

    ar_state_e   ar_state_q, ar_state_d;
    ar_kind_e    kind_q, kind_d;
    logic [HW-1:0] hart_q, hart_d;
    logic        wr_q, wr_d;
    logic [11:0] ad_q, ad_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] di_q, di_d;
    logic        err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        tgt_halted, last_cycle, port_gpr, port_csr;

    // Per-hart request decode and internal dcsr/dpc write strobes
    always_comb begin
        halt_sel   = '0;
        resume_sel = '0;
        dpc_we     = '0;
        dcsr_we    = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            halt_sel[h]   = haltreq_i   && (hartsel_i == HW'(h));
            resume_sel[h] = resumereq_i && (hartsel_i == HW'(h));
            dpc_we[h]     = (ar_state_q == AR_ACCESS) && wr_q && (kind_q == AK_DPC)
                            && (hart_q == HW'(h));
            dcsr_we[h]    = (ar_state_q == AR_ACCESS) && wr_q && (kind_q == AK_DCSR)
                            && (hart_q == HW'(h));
        end
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        hart_dbg_fsm #(
            .RESET_PC (RESET_PC)
        ) u_hart (
            .clk_i           (clk_i),
            .reset_i         (reset_i),
            .halt_req_i      (halt_sel[h]),
            .resume_req_i    (resume_sel[h]),
            .ebreak_i        (ebreak_i[h]),
            .ebreak_pc_i     (ebreak_pc_i[h*32 +: 32]),
            .next_pc_i       (next_pc_i[h*32 +: 32]),
            .fetch_busy_i    (fetch_busy_i[h]),
            .inst_valid_wb_i (inst_valid_wb_i[h]),
            .dpc_we_i        (dpc_we[h]),
            .dcsr_we_i       (dcsr_we[h]),
            .wdata_i         (wdata_q),
            .halt_o          (halt_o[h]),
            .resume_o        (resume_o[h]),
            .resume_pc_o     (resume_pc_o[h*32 +: 32]),
            .halted_o        (halted_o[h]),
            .running_o       (running_o[h]),
            .resumeack_o     (resumeack_o[h]),
            .dpc_o           (dpc_w[h]),
            .dcsr_o          (dcsr_w[h])
        );
    end

    assign tgt_halted = (int'(hartsel_i) < NUM_HARTS) && halted_o[hartsel_i];
    // dcsr/dpc complete after one access cycle, port accesses after AR_LAT
    assign last_cycle = (kind_q == AK_DCSR) || (kind_q == AK_DPC) ||
                        (cnt_q == 3'(AR_LAT - 1));

    // Abstract access FSM: launch/validate, hold port request, report
    always_comb begin
        ar_state_d = ar_state_q;
        kind_d     = kind_q;
        hart_d     = hart_q;
        wr_d       = wr_q;
        ad_d       = ad_q;
        wdata_d    = wdata_q;
        di_d       = di_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (ar_state_q)
            AR_IDLE: begin
                if (ar_en_i) begin
                    hart_d  = hartsel_i;
                    wr_d    = ar_wr_i;
                    ad_d    = ar_ad_i[11:0];
                    wdata_d = ar_do_i;
                    cnt_d   = 3'd0;
                    if (!tgt_halted || (ar_ad_i > GPR_LAST)) begin
                        err_d      = 1'b1;
                        ar_state_d = AR_DONE;
                    end else begin
                        err_d      = 1'b0;
                        ar_state_d = AR_ACCESS;
                        if (ar_ad_i == DCSR_AD) begin
                            kind_d = AK_DCSR;
                        end else if (ar_ad_i == DPC_AD) begin
                            kind_d = AK_DPC;
                        end else if (ar_ad_i >= GPR_BASE) begin
                            kind_d = AK_GPR;
                        end else begin
                            kind_d = AK_CSR;
                        end
                    end
                end
            end
            AR_ACCESS: begin
                cnt_d = cnt_q + 3'd1;
                if (last_cycle) begin
                    ar_state_d = AR_DONE;
                    if (!wr_q) begin
                        case (kind_q)
                            AK_DCSR: di_d = dcsr_w[hart_q];
                            AK_DPC:  di_d = dpc_w[hart_q];
                            AK_GPR:  di_d = gpr_rdata_i;
                            default: di_d = csr_rdata_i;
                        endcase
                    end
                end
            end
            AR_DONE: ar_state_d = AR_IDLE;
            default: ar_state_d = AR_IDLE;
        endcase
    end

    // Abstract access registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ar_state_q <= AR_IDLE;
            kind_q     <= AK_DCSR;
            hart_q     <= '0;
            wr_q       <= 1'b0;
            ad_q       <= 12'h0;
            wdata_q    <= 32'h0;
            di_q       <= 32'h0;
            err_q      <= 1'b0;
            cnt_q      <= 3'd0;
        end else begin
            ar_state_q <= ar_state_d;
            kind_q     <= kind_d;
            hart_q     <= hart_d;
            wr_q       <= wr_d;
            ad_q       <= ad_d;
            wdata_q    <= wdata_d;
            di_q       <= di_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign port_gpr    = (ar_state_q == AR_ACCESS) && (kind_q == AK_GPR);
    assign port_csr    = (ar_state_q == AR_ACCESS) && (kind_q == AK_CSR);
    assign gpr_en_o    = port_gpr;
    assign gpr_wr_o    = port_gpr && wr_q;
    assign gpr_ad_o    = port_gpr ? ad_q[4:0] : 5'h0;
    assign gpr_wdata_o = port_gpr ? wdata_q : 32'h0;
    assign csr_en_o    = port_csr;
    assign csr_wr_o    = port_csr && wr_q;
    assign csr_ad_o    = port_csr ? ad_q : 12'h0;
    assign csr_wdata_o = port_csr ? wdata_q : 32'h0;
    assign gpr_hart_o  = hart_q;
    assign ar_done_o   = (ar_state_q == AR_DONE);
    assign ar_err_o    = err_q;
    assign ar_di_o     = di_q;

    assign anyhalted_o  = |halted_o;
    assign allhalted_o  = &halted_o;
    assign anyrunning_o = |running_o;
    assign allrunning_o = &running_o;

endmodule
`default_nettype wire

// File: tb/tb_dbg_hart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbg_hart_ctrl
//  Description : Self-checking bench for dbg_hart_ctrl (2 harts, AR_LAT=2)
//                against a behavioural model of hart status and debug CSRs.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dbg_hart_ctrl;

    localparam int NH     = 2;
    localparam int HW     = 1;
    localparam int AR_LAT = 2;

    logic            clk = 1'b0;
    logic            reset_i = 1'b0;
    logic [HW-1:0]   hartsel_i = '0;
    logic            haltreq_i = 1'b0, resumereq_i = 1'b0;
    logic [NH-1:0]   ebreak_i = '0, fetch_busy_i = '0, inst_valid_wb_i = '0;
    logic [NH*32-1:0] ebreak_pc_i = '0, next_pc_i = '0;
    logic [NH-1:0]   halt_o, resume_o, halted_o, running_o, resumeack_o;
    logic [NH*32-1:0] resume_pc_o;
    logic            anyhalted_o, allhalted_o, anyrunning_o, allrunning_o;
    logic            ar_en_i = 1'b0, ar_wr_i = 1'b0;
    logic [15:0]     ar_ad_i = '0;
    logic [31:0]     ar_do_i = '0, ar_di_o;
    logic            ar_done_o, ar_err_o;
    logic            gpr_en_o, gpr_wr_o, csr_en_o, csr_wr_o;
    logic [4:0]      gpr_ad_o;
    logic [11:0]     csr_ad_o;
    logic [31:0]     gpr_wdata_o, csr_wdata_o;
    logic [31:0]     gpr_rdata_i = '0, csr_rdata_i = '0;
    logic [HW-1:0]   gpr_hart_o;

    dbg_hart_ctrl #(.NUM_HARTS(NH), .AR_LAT(AR_LAT), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .reset_i(reset_i), .hartsel_i(hartsel_i),
        .haltreq_i(haltreq_i), .resumereq_i(resumereq_i),
        .ebreak_i(ebreak_i), .ebreak_pc_i(ebreak_pc_i), .next_pc_i(next_pc_i),
        .fetch_busy_i(fetch_busy_i), .inst_valid_wb_i(inst_valid_wb_i),
        .halt_o(halt_o), .resume_o(resume_o), .resume_pc_o(resume_pc_o),
        .halted_o(halted_o), .running_o(running_o), .resumeack_o(resumeack_o),
        .anyhalted_o(anyhalted_o), .allhalted_o(allhalted_o),
        .anyrunning_o(anyrunning_o), .allrunning_o(allrunning_o),
        .ar_en_i(ar_en_i), .ar_wr_i(ar_wr_i), .ar_ad_i(ar_ad_i), .ar_do_i(ar_do_i),
        .ar_di_o(ar_di_o), .ar_done_o(ar_done_o), .ar_err_o(ar_err_o),
        .gpr_en_o(gpr_en_o), .gpr_wr_o(gpr_wr_o), .gpr_ad_o(gpr_ad_o),
        .gpr_wdata_o(gpr_wdata_o), .gpr_rdata_i(gpr_rdata_i),
        .csr_en_o(csr_en_o), .csr_wr_o(csr_wr_o), .csr_ad_o(csr_ad_o),
        .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i),
        .gpr_hart_o(gpr_hart_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model of each hart's debug-visible state
    bit          m_halted [NH];
    logic [31:0] m_dpc    [NH];
    bit          m_ebk    [NH];
    bit          m_step   [NH];
    logic [2:0]  m_cause  [NH];
    bit          m_ack    [NH];
    logic [31:0] m_di;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_dcsr(input int h);
        return 32'h4000_0003 | (32'(m_ebk[h]) << 15) | (32'(m_cause[h]) << 6)
               | (32'(m_step[h]) << 2);
    endfunction

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            m_halted[h] = 0; m_dpc[h] = 32'h0; m_ebk[h] = 0;
            m_step[h] = 0; m_cause[h] = 3'd0; m_ack[h] = 0;
        end
        m_di = 32'h0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; tick(); tick(); reset_i = 1'b0;
        model_reset();
        tests_run++; if (running_o !== 2'b11) begin tests_failed++; $display("FAIL reset_running: got %b expected 11", running_o); end
        tests_run++; if ({halted_o, halt_o} !== 4'b0) begin tests_failed++; $display("FAIL reset_halted: got %b expected 0000", {halted_o, halt_o}); end
        tests_run++; if ({resume_o, resumeack_o} !== 4'b0) begin tests_failed++; $display("FAIL reset_resume: got %b expected 0000", {resume_o, resumeack_o}); end
        tests_run++; if ({anyhalted_o, allhalted_o, anyrunning_o, allrunning_o} !== 4'b0011) begin tests_failed++; $display("FAIL reset_summary: got %b expected 0011", {anyhalted_o, allhalted_o, anyrunning_o, allrunning_o}); end
        tests_run++; if (resume_pc_o !== 64'h0) begin tests_failed++; $display("FAIL reset_dpc: got %h expected 0", resume_pc_o); end
        tests_run++; if ({ar_done_o, ar_err_o, gpr_en_o, csr_en_o, ar_di_o} !== 36'h0) begin tests_failed++; $display("FAIL reset_ar: got %h expected 0", {ar_done_o, ar_err_o, gpr_en_o, csr_en_o, ar_di_o}); end
    endtask

    // Halt hart h; fetch stays busy for busy_n cycles after entering pending
    task automatic test_halt_op(input int h, input int busy_n, input logic [31:0] pc);
        hartsel_i = HW'(h);
        haltreq_i = 1'b1;
        if (m_halted[h]) begin
            tick(); tick();
            haltreq_i = 1'b0;
            tests_run++; if (halted_o[h] !== 1'b1 || resume_o !== '0) begin tests_failed++; $display("FAIL halt_again h=%0d: got halted=%b resume=%b expected 1 00", h, halted_o[h], resume_o); end
            return;
        end
        fetch_busy_i[h] = 1'b1;
        next_pc_i[h*32 +: 32] = ~pc;
        tick();
        for (int i = 0; i < busy_n; i++) begin
            tests_run++; if ({halt_o[h], halted_o[h]} !== 2'b10) begin tests_failed++; $display("FAIL halt_pend h=%0d: got %b expected 10", h, {halt_o[h], halted_o[h]}); end
            tick();
        end
        next_pc_i[h*32 +: 32] = pc;
        fetch_busy_i[h] = 1'b0;
        tests_run++; if ({halt_o[h], halted_o[h]} !== 2'b10) begin tests_failed++; $display("FAIL halt_pend_last h=%0d: got %b expected 10", h, {halt_o[h], halted_o[h]}); end
        tick();
        haltreq_i = 1'b0;
        tests_run++; if ({halt_o[h], halted_o[h], running_o[h]} !== 3'b110) begin tests_failed++; $display("FAIL halt_done h=%0d: got %b expected 110", h, {halt_o[h], halted_o[h], running_o[h]}); end
        m_halted[h] = 1; m_dpc[h] = pc; m_cause[h] = 3'd3;
    endtask

    // One abstract access with full latency/port/result checking
    task automatic test_access_op(input int h, input bit wr, input logic [15:0] ad, input logic [31:0] wd);
        logic [31:0] rd_g, rd_c, exp_di;
        bit exp_err, internal, bad_port;
        int exp_lat, exp_g, exp_c, lat, gc, cc;
        rd_g = $urandom; rd_c = $urandom;
        gpr_rdata_i = rd_g; csr_rdata_i = rd_c;
        exp_err  = !m_halted[h] || (ad > 16'h101F);
        internal = (ad == 16'h07B0) || (ad == 16'h07B1);
        exp_lat  = exp_err ? 1 : (internal ? 2 : AR_LAT + 1);
        exp_g    = (!exp_err && ad >= 16'h1000) ? AR_LAT : 0;
        exp_c    = (!exp_err && !internal && ad < 16'h1000) ? AR_LAT : 0;
        exp_di   = m_di;
        if (!exp_err && !wr)
            exp_di = (ad == 16'h07B0) ? exp_dcsr(h) : (ad == 16'h07B1) ? m_dpc[h]
                   : (ad >= 16'h1000) ? rd_g : rd_c;
        hartsel_i = HW'(h); ar_en_i = 1'b1; ar_wr_i = wr; ar_ad_i = ad; ar_do_i = wd;
        tick();
        ar_en_i = 1'b0;
        lat = 0; gc = 0; cc = 0; bad_port = 0;
        for (int c = 1; c <= 12; c++) begin
            if (gpr_en_o) begin
                gc++;
                if (gpr_ad_o !== ad[4:0] || gpr_wr_o !== wr || gpr_hart_o !== HW'(h) || (wr && gpr_wdata_o !== wd)) bad_port = 1;
            end
            if (csr_en_o) begin
                cc++;
                if (csr_ad_o !== ad[11:0] || csr_wr_o !== wr || gpr_hart_o !== HW'(h) || (wr && csr_wdata_o !== wd)) bad_port = 1;
            end
            if (ar_done_o) begin lat = c; break; end
            tick();
        end
        tests_run++; if (lat != exp_lat) begin tests_failed++; $display("FAIL ar_latency ad=%h: got %0d expected %0d", ad, lat, exp_lat); end
        tests_run++; if (ar_err_o !== exp_err) begin tests_failed++; $display("FAIL ar_err ad=%h h=%0d: got %b expected %b", ad, h, ar_err_o, exp_err); end
        tests_run++; if (ar_di_o !== exp_di) begin tests_failed++; $display("FAIL ar_di ad=%h h=%0d: got %h expected %h", ad, h, ar_di_o, exp_di); end
        tests_run++; if (gc != exp_g || cc != exp_c || bad_port) begin tests_failed++; $display("FAIL ar_port ad=%h: got gpr=%0d csr=%0d bad=%0d expected gpr=%0d csr=%0d bad=0", ad, gc, cc, bad_port, exp_g, exp_c); end
        tick();
        tests_run++; if (ar_done_o !== 1'b0 || ar_di_o !== exp_di) begin tests_failed++; $display("FAIL ar_after ad=%h: got done=%b di=%h expected 0 %h", ad, ar_done_o, ar_di_o, exp_di); end
        if (!exp_err && wr) begin
            if (ad == 16'h07B0) begin
                m_ebk[h] = wd[15];
`ifdef DBG_SINGLE_STEP_EN
                m_step[h] = wd[2];
`endif
            end
            if (ad == 16'h07B1) m_dpc[h] = wd;
        end
        m_di = exp_di;
    endtask

    task automatic test_resume_op(input int h);
        logic [NH-1:0] exp_r;
        exp_r = '0; exp_r[h] = 1'b1;
        hartsel_i = HW'(h); resumereq_i = 1'b1;
        tick();
        resumereq_i = 1'b0;
        if (!m_halted[h]) begin
            tests_run++; if (resume_o !== '0 || resumeack_o[h] !== m_ack[h]) begin tests_failed++; $display("FAIL resume_ignored h=%0d: got resume=%b ack=%b expected 00 %b", h, resume_o, resumeack_o[h], m_ack[h]); end
            return;
        end
        tests_run++; if (resume_o !== exp_r || resume_pc_o[h*32 +: 32] !== m_dpc[h]) begin tests_failed++; $display("FAIL resume_pulse h=%0d: got %b pc=%h expected %b pc=%h", h, resume_o, resume_pc_o[h*32 +: 32], exp_r, m_dpc[h]); end
        tests_run++; if ({resumeack_o[h], halted_o[h]} !== 2'b00) begin tests_failed++; $display("FAIL resume_pend h=%0d: got %b expected 00", h, {resumeack_o[h], halted_o[h]}); end
        tick();
        tests_run++; if (resume_o !== '0 || {running_o[h], resumeack_o[h], halt_o[h]} !== 3'b110) begin tests_failed++; $display("FAIL resume_done h=%0d: got resume=%b rah=%b expected 00 110", h, resume_o, {running_o[h], resumeack_o[h], halt_o[h]}); end
        m_halted[h] = 0; m_ack[h] = 1;
    endtask

    task automatic test_halt_directed();
        test_halt_op(1, 3, 32'h100);
        tests_run++; if ({anyhalted_o, allhalted_o} !== 2'b10) begin tests_failed++; $display("FAIL halt_summary: got %b expected 10", {anyhalted_o, allhalted_o}); end
        test_access_op(1, 0, 16'h07B1, 32'h0);
        test_access_op(1, 0, 16'h07B0, 32'h0);
        test_access_op(1, 0, 16'h1005, 32'h0);
        test_access_op(1, 1, 16'h100A, $urandom);
        test_access_op(1, 0, 16'h0300, 32'h0);
    endtask

    task automatic test_errors();
        test_access_op(0, 0, 16'h1001, 32'h0);
        test_access_op(1, 0, 16'h2000, 32'h0);
        test_access_op(1, 1, 16'h1020, 32'h1234);
    endtask

    task automatic test_resume();
        test_access_op(1, 1, 16'h07B1, 32'h200);
        test_resume_op(1);
        test_resume_op(1);
    endtask

    task automatic test_resume_blocked();
        test_halt_op(0, 1, 32'h0000_0040);
        hartsel_i = 1'b0; haltreq_i = 1'b1; resumereq_i = 1'b1;
        tick();
        haltreq_i = 1'b0; resumereq_i = 1'b0;
        tick();
        tests_run++; if (resume_o !== '0 || halted_o[0] !== 1'b1) begin tests_failed++; $display("FAIL resume_blocked: got resume=%b halted=%b expected 00 1", resume_o, halted_o[0]); end
    endtask

    task automatic test_ebreak();
        logic [31:0] epc;
        epc = $urandom & 32'hFFFF_FFFC;
        test_access_op(0, 1, 16'h07B0, 32'h0000_8000);
        test_resume_op(0);
        hartsel_i = 1'b0; haltreq_i = 1'b1;
        ebreak_i[0] = 1'b1; ebreak_pc_i[31:0] = epc; next_pc_i[31:0] = ~epc;
        tick();
        ebreak_i[0] = 1'b0; haltreq_i = 1'b0;
        tests_run++; if ({halt_o[0], halted_o[0]} !== 2'b10) begin tests_failed++; $display("FAIL ebreak_pend: got %b expected 10", {halt_o[0], halted_o[0]}); end
        tick();
        tests_run++; if (halted_o[0] !== 1'b1) begin tests_failed++; $display("FAIL ebreak_halt: got %b expected 1", halted_o[0]); end
        m_halted[0] = 1; m_dpc[0] = epc; m_cause[0] = 3'd1;
        test_access_op(0, 0, 16'h07B1, 32'h0);
        test_access_op(0, 0, 16'h07B0, 32'h0);
        test_access_op(0, 1, 16'h07B0, 32'h0);
    endtask

    task automatic test_step();
        test_halt_op(1, 0, 32'h0000_0180);
        test_access_op(1, 1, 16'h07B0, 32'h0000_0004);
        test_access_op(1, 0, 16'h07B0, 32'h0);
`ifdef DBG_SINGLE_STEP_EN
        test_resume_op(1);
        next_pc_i[63:32] = 32'h204; inst_valid_wb_i[1] = 1'b1;
        tick();
        inst_valid_wb_i[1] = 1'b0;
        tests_run++; if ({halt_o[1], halted_o[1]} !== 2'b10) begin tests_failed++; $display("FAIL step_pend: got %b expected 10", {halt_o[1], halted_o[1]}); end
        tick();
        tests_run++; if (halted_o[1] !== 1'b1) begin tests_failed++; $display("FAIL step_halt: got %b expected 1", halted_o[1]); end
        m_halted[1] = 1; m_dpc[1] = 32'h204; m_cause[1] = 3'd4;
        test_access_op(1, 0, 16'h07B0, 32'h0);
        test_access_op(1, 0, 16'h07B1, 32'h0);
        test_access_op(1, 1, 16'h07B0, 32'h0);
`endif
    endtask

    task automatic test_random();
        logic [NH-1:0] mh, ma;
        logic [15:0] ad;
        logic [31:0] wd;
        int h, op;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 4);
            h  = $urandom_range(0, NH - 1);
            if (op == 0) begin
                test_halt_op(h, $urandom_range(0, 3), $urandom & 32'hFFFF_FFFC);
            end else if (op == 1) begin
                test_resume_op(h);
            end else begin
                case ($urandom_range(0, 4))
                    0: ad = 16'h07B0;
                    1: ad = 16'h07B1;
                    2: ad = 16'h1000 + 16'($urandom_range(0, 31));
                    3: ad = 16'($urandom_range(0, 16'h0FFF));
                    default: ad = 16'h1020 + 16'($urandom_range(0, 16'hE000));
                endcase
                wd = $urandom;
                if (ad == 16'h07B0) wd[2] = 1'b0;
                test_access_op(h, 1'($urandom_range(0, 1)), ad, wd);
            end
            for (int k = 0; k < NH; k++) begin mh[k] = m_halted[k]; ma[k] = m_ack[k]; end
            tests_run++; if (halted_o !== mh || running_o !== ~mh || resumeack_o !== ma) begin tests_failed++; $display("FAIL rand_status it=%0d: got h=%b r=%b a=%b expected h=%b r=%b a=%b", it, halted_o, running_o, resumeack_o, mh, ~mh, ma); end
            tests_run++; if ({anyhalted_o, allhalted_o, anyrunning_o, allrunning_o} !== {|mh, &mh, |(~mh), &(~mh)}) begin tests_failed++; $display("FAIL rand_summary it=%0d: got %b expected %b", it, {anyhalted_o, allhalted_o, anyrunning_o, allrunning_o}, {|mh, &mh, |(~mh), &(~mh)}); end
        end
    endtask

    task automatic test_reset_mid_access();
        test_halt_op(1, 0, 32'h0000_0300);
        hartsel_i = 1'b1; ar_en_i = 1'b1; ar_wr_i = 1'b0; ar_ad_i = 16'h1003;
        tick();
        ar_en_i = 1'b0;
        tests_run++; if (gpr_en_o !== 1'b1) begin tests_failed++; $display("FAIL abort_started: got %b expected 1", gpr_en_o); end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        model_reset();
        tests_run++; if ({gpr_en_o, running_o, halted_o} !== 5'b01100) begin tests_failed++; $display("FAIL abort_state: got %b expected 01100", {gpr_en_o, running_o, halted_o}); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (ar_done_o !== 1'b0 || ar_err_o !== 1'b0) begin tests_failed++; $display("FAIL abort_done cycle=%0d: got %b expected 00", i, {ar_done_o, ar_err_o}); end
            tick();
        end
        test_halt_op(0, 1, 32'h0000_0404);
        test_access_op(0, 0, 16'h07B0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_halt_directed();
        test_errors();
        test_resume();
        test_resume_blocked();
        test_ebreak();
        test_step();
        test_random();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dbg_hart_ctrl.md
Name: dbg_hart_ctrl

Overview:
- Multi-hart run-control and abstract-register-access controller between the debug module (DM) and N rv32i cores.
- Generalises the single-hart debug FSM:
  - per-hart halt/resume state, dpc and dcsr;
  - hart selection;
  - multi-cycle abstract register access with error reporting;
  - any/all status summaries.
- Drives a per-hart pipeline-stall/redirect interface.

Parameters:
- NUM_HARTS, 2, number of cores controlled (1..16).
- AR_LAT, 1, cycles from access launch to GPR/CSR read data valid (1..4).
- RESET_PC, 32'h0000_0000, reset value of every dpc.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, synchronous, active-high.
- hartsel_i  in  HW=$clog2(NUM_HARTS) (min 1)  selected hart for haltreq/resumereq/abstract access.
- haltreq_i  in  1  level; halt the selected hart.
- resumereq_i  in  1  pulse; resume the selected hart.
- ebreak_i  in  NUM_HARTS  per-hart ebreak reached MEM stage.
- ebreak_pc_i  in  NUM_HARTS*32  per-hart pc of that ebreak.
- next_pc_i  in  NUM_HARTS*32  per-hart pc of oldest unretired instruction.
- fetch_busy_i  in  NUM_HARTS  per-hart outstanding fetch.
- inst_valid_wb_i  in  NUM_HARTS  per-hart retire strobe.
- halt_o  out  NUM_HARTS  stall/flush request to each core.
- resume_o  out  NUM_HARTS  one-cycle redirect pulse; core restarts at resume_pc_o.
- resume_pc_o  out  NUM_HARTS*32  per-hart dpc.
- halted_o, running_o, resumeack_o  out  NUM_HARTS  per-hart status.
- anyhalted_o, allhalted_o, anyrunning_o, allrunning_o  out  1  summaries.
- ar_en_i, ar_wr_i  in  1  access start pulse; write flag.
- ar_ad_i  in  16  register number.
- ar_do_i  in  32  write data.
- ar_di_o  out  32  read data.
- ar_done_o, ar_err_o  out  1  completion pulse; error.
- gpr_en_o, gpr_wr_o  out  1  GPR port request.
- gpr_ad_o  out  5  GPR index.
- gpr_wdata_o  out  32  GPR write data.
- gpr_rdata_i  in  32  GPR read data.
- csr_en_o, csr_wr_o  out  1  CSR port request.
- csr_ad_o  out  12  CSR number.
- csr_wdata_o  out  32  CSR write data.
- csr_rdata_i  in  32  CSR read data.
- gpr_hart_o  out  HW  hart targeted by the GPR/CSR port.

Behaviour:
- Reset values:
  - All harts RUNNING; running_o all ones; halted_o, halt_o, resume_o, resumeack_o zero.
  - dpc = RESET_PC; dcsr = 32'h4000_0003 (xdebugver=4, prv=M).
  - All ar_* and gpr_*/csr_* outputs zero.
  - Reset mid-access aborts the access with no done pulse.
- Per-hart FSM, states RUNNING, HALT_PEND, HALTED, RESUME_PEND:
  - RUNNING -> HALT_PEND:
    - on haltreq_i with hartsel_i==h: cause=3;
    - or on ebreak_i[h] with dcsr.ebreakm=1: cause=1, dpc captured from ebreak_pc_i;
    - ebreak wins over haltreq in the same cycle.
  - In HALT_PEND, halt_o=1. Wait until fetch_busy_i[h]=0, then go to HALTED the next cycle. For a haltreq, dpc is captured from next_pc_i at that transition.
  - HALTED: halted_o=1, halt_o=1.
  - resumereq_i for the selected hart while HALTED:
    - clears resumeack_o;
    - goes to RESUME_PEND;
    - resume_o[h] pulses for exactly 1 cycle with resume_pc_o=dpc;
    - returns to RUNNING the next cycle and sets resumeack_o[h] (sticky until the next resumereq to that hart).
  - resumereq_i while haltreq_i is also asserted for the same hart: resume is ignored.
  - resumereq_i to a hart that is not halted: ignored.
  - haltreq_i to a hart already halted: no effect.
- dcsr writable fields: step[2], ebreakm[15]. cause[8:6] is read-only.
- Abstract access FSM, states IDLE, ACCESS, DONE:
  - ar_en_i in IDLE latches ad, wr, do and hartsel.
  - If the target hart is not HALTED, or ad>16'h101F: DONE with ar_err_o=1 and no port request.
  - Otherwise:
    - 16'h07B0/16'h07B1 access the internal dcsr/dpc, latency 1;
    - 16'h1000-16'h101F use the GPR port;
    - other values <16'h1000 use the CSR port.
    - The port request is held for AR_LAT cycles; data is sampled on the last cycle.
  - DONE: ar_done_o pulses 1 cycle; ar_di_o is held until the next access; back to IDLE.
  - ar_en_i while not IDLE is ignored.
  - Total latency ar_en -> done: AR_LAT+1 cycles for port accesses, 2 cycles for dcsr/dpc.

Optional Feature:
- Macro DBG_SINGLE_STEP_EN.
- Defined: when resuming with dcsr.step=1, the hart runs until the first inst_valid_wb_i[h], then auto-enters HALT_PEND with cause=4 and dpc=next_pc_i. A haltreq in the same cycle wins (cause=3).
- Undefined: the step bit reads 0 and is not writable; no auto-halt.

Decomposition:
- Package dbg_pkg:
  - hart_state_e enum;
  - ar_state_e enum;
  - cause constants CAUSE_EBREAK=1, CAUSE_HALTREQ=3, CAUSE_STEP=4;
  - addresses DCSR_AD=16'h07B0, DPC_AD=16'h07B1, GPR_BASE=16'h1000, GPR_LAST=16'h101F;
  - DCSR_RESET constant.
- Sub-module hart_dbg_fsm, instantiated NUM_HARTS times via generate. It owns one hart's state, dpc and dcsr.
- The top level holds the abstract access FSM, hartsel decode and summaries.

Test Plan:
- Reset, NUM_HARTS=2 -> running_o=2'b11, allrunning_o=1, dpc read later equals 0, dcsr=32'h4000_0003.
- hartsel=1, haltreq=1, fetch_busy_i[1]=1 for 3 cycles, next_pc_i[1]=32'h100 -> halted_o[1] rises 1 cycle after busy drops; dpc=32'h100; cause=3; anyhalted_o=1, allhalted_o=0.
- Hart 1 halted; ar_en, ad=16'h1005, AR_LAT=2, gpr_rdata_i=32'hDEAD_BEEF -> gpr_ad_o=5 for 2 cycles; ar_done_o 3 cycles after ar_en; ar_di_o=32'hDEAD_BEEF; ar_err_o=0.
- ar_en to hart 0 while running, or ad=16'h2000 -> ar_done_o with ar_err_o=1; no gpr_en_o/csr_en_o activity.
- Write dpc=32'h200, then resumereq to hart 1 -> resume_o[1] single pulse with resume_pc_o=32'h200; resumeack_o[1]=1; running_o[1]=1.
- DBG_SINGLE_STEP_EN: write dcsr.step=1, resume, one inst_valid_wb_i[1] with next_pc_i=32'h204 -> re-halt with cause=4, dpc=32'h204.
